// File: rtl/uart_pkg.sv
// Shared constants for the FIFO-fed UART transmitter: FSM encoding,
// frame-bit levels and a constant-evaluable log2 helper.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_START  = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_PARITY = 3'd5;
    localparam logic [2:0] ST_STOP   = 3'd6;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each serial bit; clear restarts the period on FSM state entry.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (clog2(CLKS_PER_BIT) < 1) ? 1 : clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains an upstream synchronous FIFO one byte at a
// time: fetch, load, then start / data (LSB first) / optional parity / stop.
//
// state  | meaning
// IDLE   | line high, waiting for enable with FIFO non-empty
// FETCH  | one-cycle rd_en pulse to the FIFO
// LOAD   | FIFO data valid; latch shift register and parity
// START  | start bit (low) for one bit period
// DATA   | WIDTH data bits, shift register LSB on the line
// PARITY | even parity bit (only when PARITY_EN)
// STOP   | stop bit (high); tx_done on its last cycle
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd_en,
    output logic             tx,
    output logic             busy,
    output logic             tx_done
);

    localparam int BW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    logic [2:0]       state, state_nxt;
    logic [WIDTH-1:0] shift_q, shift_nxt;
    logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
    logic             parity_q;
    logic             tx_q, tx_nxt;
    logic             baud_clear;
    logic             baud_tick;

    // The baud period restarts whenever the FSM enters a new state.
    assign baud_clear = (state_nxt != state) || (state == ST_IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(baud_clear),
        .tick (baud_tick)
    );

    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_q;
        bit_cnt_nxt = bit_cnt;
        case (state)
            ST_IDLE: begin
                if (enable && !fifo_empty) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                shift_nxt   = fifo_data;
                bit_cnt_nxt = '0;
                state_nxt   = ST_START;
            end
            ST_START: begin
                if (baud_tick) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BW'(1);
                        shift_nxt   = shift_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (baud_tick) begin
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    state_nxt = (enable && !fifo_empty) ? ST_FETCH : ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Line level is decided from the next state so tx leaves a flop aligned with state.
    always_comb begin
        tx_nxt = STOP_BIT;
        case (state_nxt)
            ST_START:  tx_nxt = START_BIT;
            ST_DATA:   tx_nxt = shift_nxt[0];
            ST_PARITY: tx_nxt = parity_q;
            default:   tx_nxt = STOP_BIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            shift_q  <= '0;
            bit_cnt  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state   <= state_nxt;
            shift_q <= shift_nxt;
            bit_cnt <= bit_cnt_nxt;
            tx_q    <= tx_nxt;
            if (state == ST_LOAD) begin
                parity_q <= ^fifo_data;
            end
        end
    end

    assign tx         = tx_q;
    assign fifo_rd_en = (state == ST_FETCH);
    assign busy       = (state != ST_IDLE);
    assign tx_done    = (state == ST_STOP) && baud_tick;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: two instances (no parity / even parity),
// each fed by a small behavioural FIFO, with a line decoder on each tx.
module tb_fifo_uart_tx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       en       [2];
    logic       empty_w  [2];
    logic [7:0] fdata    [2];
    logic       rd_en_w  [2];
    logic       tx_w     [2];
    logic       busy_w   [2];
    logic       done_w   [2];

    logic [7:0] mem [2][64];
    int         wr  [2];
    int         rd  [2];
    int         cyc;

    int          rd_cnt [2];
    int          rd_cyc [2];
    int          rd_empty_err [2];
    int          done_cnt [2];
    int          done_cyc [2];
    int          nst [2];
    int          nfrm [2];
    int          st_cyc [2][64];
    int          rx_t0 [2];
    logic        rx_act [2];
    logic        prev_tx [2];
    logic [10:0] rx_bits [2];
    logic [10:0] frm [2][64];

    int nvec;
    int nmis;

    always #5 clk = ~clk;

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut0 (
        .clk(clk), .rst(rst), .enable(en[0]), .fifo_empty(empty_w[0]),
        .fifo_data(fdata[0]), .fifo_rd_en(rd_en_w[0]), .tx(tx_w[0]),
        .busy(busy_w[0]), .tx_done(done_w[0])
    );

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut1 (
        .clk(clk), .rst(rst), .enable(en[1]), .fifo_empty(empty_w[1]),
        .fifo_data(fdata[1]), .fifo_rd_en(rd_en_w[1]), .tx(tx_w[1]),
        .busy(busy_w[1]), .tx_done(done_w[1])
    );

    assign empty_w[0] = (wr[0] == rd[0]);
    assign empty_w[1] = (wr[1] == rd[1]);

    // Registered-read FIFO: data valid the cycle after rd_en is sampled.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                rd[k]    <= wr[k];
                fdata[k] <= 8'h00;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (rd_en_w[k] && !empty_w[k]) begin
                    fdata[k] <= mem[k][rd[k] % 64];
                    rd[k]    <= rd[k] + 1;
                end
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: counts pulses and decodes frames by sampling mid-bit.
    initial begin
        for (int k = 0; k < 2; k++) begin
            prev_tx[k] = 1'b1;
            rx_act[k]  = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    rx_act[k] = 1'b0;
                end else begin
                    if (rd_en_w[k]) begin
                        rd_cnt[k] = rd_cnt[k] + 1;
                        rd_cyc[k] = cyc;
                        if (empty_w[k]) rd_empty_err[k] = rd_empty_err[k] + 1;
                    end
                    if (done_w[k]) begin
                        done_cnt[k] = done_cnt[k] + 1;
                        done_cyc[k] = cyc;
                    end
                    if (!rx_act[k] && prev_tx[k] && !tx_w[k]) begin
                        rx_act[k]  = 1'b1;
                        rx_t0[k]   = cyc;
                        rx_bits[k] = '0;
                        st_cyc[k][nst[k] % 64] = cyc;
                        nst[k] = nst[k] + 1;
                    end
                    if (rx_act[k]) begin
                        int off;
                        off = cyc - rx_t0[k];
                        if (off % CPB == CPB / 2) begin
                            rx_bits[k][off / CPB] = tx_w[k];
                            if (off / CPB == ((k == 1) ? 10 : 9)) begin
                                rx_act[k] = 1'b0;
                                frm[k][nfrm[k] % 64] = rx_bits[k];
                                nfrm[k] = nfrm[k] + 1;
                            end
                        end
                    end
                end
                prev_tx[k] = tx_w[k];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        nvec = nvec + 1;
        if (act != exp) begin
            nmis = nmis + 1;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [7:0] d);
        mem[k][wr[k] % 64] = d;
        wr[k] = wr[k] + 1;
    endtask

    typedef struct {
        int          k;
        logic [7:0]  data;
        logic [10:0] exp;
        int          len;
    } vec_t;

    vec_t       vt [6];
    logic [7:0] bd [16];

    initial begin
        int k, fb, rb, db, sb, eb, n, cnt;

        // Expected line samples, bit i = i-th bit period (start first).
        vt[0] = '{0, 8'hA5, 11'b01101001010, 160};
        vt[1] = '{1, 8'hA5, 11'b10101001010, 176};
        vt[2] = '{1, 8'h07, 11'b11000001110, 176};
        vt[3] = '{0, 8'h3C, 11'b01001111000, 160};
        vt[4] = '{0, 8'hFF, 11'b01111111110, 160};
        vt[5] = '{1, 8'h00, 11'b10000000000, 176};

        nvec  = 0;
        nmis  = 0;
        rst   = 1'b1;
        en[0] = 1'b0;
        en[1] = 1'b0;
        repeat (3) tick();
        for (int j = 0; j < 2; j++) begin
            check($sformatf("rst_tx%0d", j), int'(tx_w[j]), 1);
            check($sformatf("rst_busy%0d", j), int'(busy_w[j]), 0);
            check($sformatf("rst_rd_en%0d", j), int'(rd_en_w[j]), 0);
            check($sformatf("rst_done%0d", j), int'(done_w[j]), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            k  = vt[i].k;
            fb = nfrm[k];
            rb = rd_cnt[k];
            db = done_cnt[k];
            push(k, vt[i].data);
            en[k] = 1'b1;
            n = 0;
            while ((nfrm[k] == fb || busy_w[k]) && n < 400) begin
                tick();
                n++;
            end
            en[k] = 1'b0;
            check($sformatf("v%0d_timeout", i), int'(n < 400), 1);
            check($sformatf("v%0d_bits", i), int'(frm[k][fb % 64]), int'(vt[i].exp));
            check($sformatf("v%0d_len", i),
                  done_cyc[k] - st_cyc[k][(nst[k] - 1) % 64] + 1, vt[i].len);
            check($sformatf("v%0d_rd_to_start", i),
                  st_cyc[k][(nst[k] - 1) % 64] - rd_cyc[k], 2);
            check($sformatf("v%0d_rd_pulses", i), rd_cnt[k] - rb, 1);
            check($sformatf("v%0d_done_pulses", i), done_cnt[k] - db, 1);
            check($sformatf("v%0d_empty_after", i), int'(empty_w[k]), 1);
        end

        // Burst drain of 16 bytes.
        fb = nfrm[0];
        db = done_cnt[0];
        sb = nst[0];
        eb = rd_empty_err[0];
        for (int i = 0; i < 16; i++) begin
            bd[i] = 8'($urandom_range(0, 255));
            push(0, bd[i]);
        end
        en[0] = 1'b1;
        n   = 0;
        cnt = 0;
        while (done_cnt[0] < db + 16 && n < 3000) begin
            tick();
            n++;
            if (nst[0] > sb && done_cnt[0] < db + 16 && !busy_w[0]) cnt++;
        end
        check("burst_timeout", int'(n < 3000), 1);
        check("burst_busy_drop", cnt, 0);
        check("burst_busy_end", int'(busy_w[0]), 0);
        en[0] = 1'b0;
        check("burst_frames", nfrm[0] - fb, 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("burst_byte%0d", i), int'(frm[0][(fb + i) % 64]),
                  int'({2'b01, bd[i], 1'b0}));
        end
        for (int i = 1; i < 16; i++) begin
            check($sformatf("burst_gap%0d", i),
                  st_cyc[0][(sb + i) % 64] - st_cyc[0][(sb + i - 1) % 64], 162);
        end
        check("burst_rd_empty", rd_empty_err[0] - eb, 0);

        // Enable with an empty FIFO.
        rb  = rd_cnt[0];
        cnt = 0;
        en[0] = 1'b1;
        repeat (100) begin
            tick();
            if (!tx_w[0]) cnt++;
        end
        en[0] = 1'b0;
        check("empty_rd_pulses", rd_cnt[0] - rb, 0);
        check("empty_tx_low", cnt, 0);
        check("empty_busy", int'(busy_w[0]), 0);

        // Drop enable while byte 3 of 5 is on the line.
        fb = nfrm[0];
        sb = nst[0];
        db = done_cnt[0];
        for (int i = 0; i < 5; i++) push(0, 8'(8'h11 * (i + 1)));
        en[0] = 1'b1;
        n = 0;
        while (nst[0] < sb + 3 && n < 600) begin
            tick();
            n++;
        end
        check("gate_start3_timeout", int'(n < 600), 1);
        repeat (50) tick();
        en[0] = 1'b0;
        n = 0;
        while (busy_w[0] && n < 400) begin
            tick();
            n++;
        end
        check("gate_idle_timeout", int'(n < 400), 1);
        repeat (300) tick();
        check("gate_starts", nst[0] - sb, 3);
        check("gate_frames", nfrm[0] - fb, 3);
        check("gate_fifo_left", wr[0] - rd[0], 2);
        en[0] = 1'b1;
        n = 0;
        while ((done_cnt[0] < db + 5 || busy_w[0]) && n < 800) begin
            tick();
            n++;
        end
        en[0] = 1'b0;
        check("gate_drain_timeout", int'(n < 800), 1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("gate_byte%0d", i), int'(frm[0][(fb + i) % 64]),
                  int'({2'b01, 8'(8'h11 * (i + 1)), 1'b0}));
        end

        // Reset in the middle of data bit 4 of 0x81 (that bit is 0 on the line).
        sb = nst[0];
        push(0, 8'h81);
        en[0] = 1'b1;
        n = 0;
        while (nst[0] == sb && n < 50) begin
            tick();
            n++;
        end
        check("rst_start_timeout", int'(n < 50), 1);
        fb = nfrm[0];
        n = 0;
        while (cyc < st_cyc[0][sb % 64] + 88 && n < 200) begin
            tick();
            n++;
        end
        check("rst_pre_tx", int'(tx_w[0]), 0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_tx", int'(tx_w[0]), 1);
        check("rst_async_busy", int'(busy_w[0]), 0);
        check("rst_async_rd_en", int'(rd_en_w[0]), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("rst_fifo_empty", int'(empty_w[0]), 1);
        check("rst_no_frame", nfrm[0] - fb, 0);
        db = done_cnt[0];
        push(0, 8'h3C);
        n = 0;
        while ((nfrm[0] == fb || busy_w[0]) && n < 400) begin
            tick();
            n++;
        end
        en[0] = 1'b0;
        check("rst_after_timeout", int'(n < 400), 1);
        check("rst_after_bits", int'(frm[0][fb % 64]), int'(11'b01001111000));
        check("rst_after_done", done_cnt[0] - db, 1);
        check("rst_after_len", done_cyc[0] - st_cyc[0][(nst[0] - 1) % 64] + 1, 160);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
